// File: rtl/rr_arb_mux.sv
// rr_arb_mux: registered CH-channel valid/ready merge with round-robin or fixed-priority
// arbitration and packet locking on per-channel last flags.
module rr_arb_mux #(
  parameter int N = 64,
  parameter int CH = 4,
  localparam int SW = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mode,
  input  logic [CH-1:0]   in_valid,
  input  logic [CH-1:0]   in_last,
  input  logic [CH*N-1:0] in_data,
  output logic [CH-1:0]   in_ready,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N-1:0]    out_data,
  output logic [SW-1:0]   out_chan,
  output logic            out_last,
  output logic            locked
);
  typedef enum logic {UNLOCKED, LOCKED} lock_e;
  lock_e         state_q, state_d;
  logic [SW-1:0] lock_chan_q, lock_chan_d, ptr_q, ptr_d, out_chan_q, out_chan_d;
  logic [SW-1:0] gnt, lo, hi;
  logic          gnt_vld, lo_v, hi_v, load, xfer, sel_last;
  logic [N-1:0]  sel_data, out_data_q, out_data_d;
  logic          out_valid_q, out_valid_d, out_last_q, out_last_d;
  assign load = ~out_valid_q | out_ready;
  // lo: lowest valid overall; hi: lowest valid at or above ptr, so RR falls back to lo on wrap
  always_comb begin
    lo = '0;
    hi = '0;
    lo_v = 1'b0;
    hi_v = 1'b0;
    for (int i = CH - 1; i >= 0; i--) begin
      if (in_valid[i]) begin
        lo = SW'(i);
        lo_v = 1'b1;
      end
      if (in_valid[i] && i >= int'(ptr_q)) begin
        hi = SW'(i);
        hi_v = 1'b1;
      end
    end
    gnt = (state_q == LOCKED) ? lock_chan_q : (mode | ~hi_v) ? lo : hi;
    gnt_vld = (state_q == LOCKED) ? in_valid[lock_chan_q] : lo_v;
    sel_data = '0;
    sel_last = 1'b0;
    for (int i = 0; i < CH; i++) begin
      if (gnt == SW'(i)) begin
        sel_data = in_data[i*N +: N];
        sel_last = in_last[i];
      end
    end
    xfer = load & gnt_vld;
    in_ready = (xfer & rst_n) ? CH'(1) << gnt : '0;
    out_valid_d = load ? gnt_vld : out_valid_q;
    out_data_d = xfer ? sel_data : out_data_q;
    out_chan_d = xfer ? gnt : out_chan_q;
    out_last_d = xfer ? sel_last : out_last_q;
    state_d = xfer ? (sel_last ? UNLOCKED : LOCKED) : state_q;
    lock_chan_d = xfer ? gnt : lock_chan_q;
    ptr_d = (xfer & sel_last & ~mode) ? ((gnt == SW'(CH - 1)) ? '0 : gnt + SW'(1)) : ptr_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q <= '0;
      out_chan_q <= '0;
      out_last_q <= 1'b0;
      state_q <= UNLOCKED;
      lock_chan_q <= '0;
      ptr_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q <= out_data_d;
      out_chan_q <= out_chan_d;
      out_last_q <= out_last_d;
      state_q <= state_d;
      lock_chan_q <= lock_chan_d;
      ptr_q <= ptr_d;
    end
  end
  assign out_valid = out_valid_q;
  assign out_data = out_data_q;
  assign out_chan = out_chan_q;
  assign out_last = out_last_q;
  assign locked = (state_q == LOCKED);
endmodule

// File: doc/rr_arb_mux.md
Name: rr_arb_mux

Overview:
- Parametrised, registered N-bit CH-channel arbitrating multiplexer. It is the sequential successor to the combinational Mux4/8/32 selectors.
- It merges CH valid/ready sources into one valid/ready sink. Selection is by round-robin or fixed priority, with packet locking via per-channel last flags.
- It sits between multiple producers (e.g. load/store, fetch, DMA ports) and a single 64-bit datapath consumer.
- It has one output register stage, with full throughput when the sink is always ready.

Parameters:
- N, 64, data width in bits.
- CH, 4, number of input channels (>=1).
- SW, $clog2(CH) (1 when CH=1), width of the channel index; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- mode  input  1  0 = round-robin, 1 = fixed priority (lowest index wins).
- in_valid  input  CH  per-channel beat valid.
- in_last  input  CH  per-channel last beat of packet; qualified by in_valid.
- in_data  input  CH*N  channel i occupies bits [i*N+N-1 : i*N].
- in_ready  output  CH  one-hot or zero; the beat on channel i transfers when in_valid[i] & in_ready[i].
- out_valid  output  1  output register holds a beat.
- out_ready  input  1  sink accepts the beat.
- out_data  output  N  registered data.
- out_chan  output  SW  registered source channel index of out_data.
- out_last  output  1  registered copy of the in_last of the held beat.
- locked  output  1  a packet is in progress (grant held).

Behaviour:
- Reset (rst_n low, asynchronous):
  - out_valid=0, out_data=0, out_chan=0, out_last=0, locked=0.
  - RR pointer=0; in_ready=0 while rst_n is low.
- Load enable: load = ~out_valid | out_ready. in_ready is all zero when load=0.
- Grant (combinational, computed when load=1):
  - When locked: grant = lock_chan if in_valid[lock_chan], else none. Other channels wait even if valid.
  - When unlocked, mode=1: lowest index i with in_valid[i].
  - When unlocked, mode=0: first valid i scanning ptr, ptr+1, ... CH-1, 0, ... ptr-1 (wraps modulo CH).
  - in_ready = onehot(grant), and only on a valid channel.
- Transfer (accepted beat at posedge):
  - out_data <= in_data[g], out_chan <= g, out_last <= in_last[g], out_valid <= 1.
- If no grant and load=1, then out_valid <= 0 and out_data, out_chan and out_last hold their old values.
- Latency: a beat accepted at edge k appears on out_* after edge k.
- Back-to-back beats every cycle while out_ready=1.
- Stall (out_valid=1, out_ready=0): all out_* stable, in_ready=0.
- Lock state machine:
  - UNLOCKED -> LOCKED: on a transfer with in_last[g]=0; lock_chan <= g.
  - LOCKED -> UNLOCKED: on a transfer with in_last=1 from lock_chan.
  - A single-beat packet (last=1 while unlocked) never locks.
- RR pointer:
  - Updates only in mode=0, on a transfer with in_last=1: ptr <= (g+1) mod CH. This includes wrap from CH-1 to 0.
  - Pointer is unchanged in mode=1 and on non-last beats.
- mode changes are sampled every cycle but affect selection only while unlocked. An in-progress packet always completes on its channel.
- Reset mid-packet: lock is cleared and any held output beat is discarded (out_valid=0). The producer is responsible for resending.
- CH=1: grant = channel 0 whenever valid; out_chan constant 0.
- in_data and in_last of non-granted channels do not affect any state.

Test Plan:
1. Reset then idle:
   - Assert rst_n=0 mid-cycle with out_valid=1 -> out_valid, locked and out_chan drop to 0 immediately, without waiting for a clock edge.
   - After release with all in_valid=0 -> out_valid stays 0.
2. Round-robin fairness:
   - Stimulus: CH=4, mode=0, in_valid=4'b1111, all in_last=1, out_ready=1, in_data[i]=64'h100+i.
   - Required: out_chan sequence 0,1,2,3,0 on consecutive cycles and out_data 64'h100..64'h103, 64'h100. This checks wrap.
3. Fixed priority starvation:
   - Stimulus: mode=1, in_valid=4'b1010, last=1.
   - Required: out_chan=1 on every cycle; channel 3 is never granted until in_valid[1] drops, then out_chan=3.
4. Packet lock:
   - Stimulus: channel 2 sends 3 beats with last=0,0,1 while channel 0 is continuously valid.
   - Required: out_chan=2,2,2 and locked=1 after beats 1-2, then 0 after beat 3; the next grant is channel 3 or 0 per the pointer (here 0 with CH=4, ptr=3).
   - With in_valid[2] deasserted for 2 cycles mid-packet: out_valid=0 for those cycles and channel 0 is not granted.
5. Backpressure:
   - Stimulus: out_ready=0 for 5 cycles with a beat held (out_data=64'hDEAD_BEEF_0000_0001).
   - Required: out_data and out_chan stable and in_ready=0 during the stall. Releasing out_ready gives the next beat on the following edge, with no loss or duplication (scoreboard count equal).
6. Mode switch mid-packet:
   - Stimulus: a locked packet on channel 1, then mode toggles 0->1 while channel 0 is valid.
   - Required: the packet completes on channel 1, then channel 0 is granted.
